// File: rtl/mc_datapath.sv
// ---------------------------------------------------------------------------
// mc_datapath
//
// Purpose: multi-cycle MIPS-subset datapath. Each instruction walks through
// FETCH, DECODE, EXEC, MEM and WB as needed, so it takes 2 to 5 clocks plus
// any memory wait cycles. Instruction fetch and data access share a single
// memory port with a req/ready handshake. An unsupported opcode or R-type
// funct parks the machine in HALT until reset.
//
// Parameters:
//   NREG      number of architectural registers (8..32). r0 reads as zero
//             and r[NREG-1] is the jal link register.
//   RESET_PC  PC value loaded on reset.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   mem_req      memory request, held until accepted
//   mem_we       write strobe qualifying mem_req
//   mem_addr     word-aligned byte address
//   mem_wdata    store data
//   mem_rdata    read data, valid while mem_ready=1
//   mem_ready    access completes at an edge where mem_req && mem_ready
//   dbg_sel      register index for the debug port
//   dbg_data     combinational read of register dbg_sel
//   pc_out       current PC register
//   instr_done   one-cycle pulse in the last cycle of each instruction
//   halted       sticky flag raised by an unsupported instruction
// ---------------------------------------------------------------------------
module mc_datapath #(
    parameter int          NREG     = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    input  logic [4:0]  dbg_sel,
    output logic [31:0] dbg_data,
    output logic [31:0] pc_out,
    output logic        instr_done,
    output logic        halted
);

    localparam int AW = $clog2(NREG);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t         r_state;
    logic [31:0]    r_pc;
    logic [31:0]    r_ir;
    logic [31:0]    r_a;
    logic [31:0]    r_b;
    logic [31:0]    r_aluOut;
    logic [31:0]    r_mdr;
    logic [31:0]    r_regs [NREG];

    logic [5:0]     w_op;
    logic [5:0]     w_funct;
    logic [AW-1:0]  w_rs;
    logic [AW-1:0]  w_rt;
    logic [AW-1:0]  w_rd;
    logic [AW-1:0]  w_dbgIdx;
    logic [31:0]    w_immSext;
    logic           w_isRtype;
    logic           w_rtypeOk;
    logic           w_isJ;
    logic           w_isJal;
    logic           w_isBeq;
    logic           w_isAddi;
    logic           w_isLw;
    logic           w_isSw;
    logic           w_legal;
    logic [31:0]    w_aluR;
    logic [AW-1:0]  w_wbIdx;
    logic [31:0]    w_wbData;

    // Instruction fields. Register fields wrap modulo NREG so that smaller
    // register files still accept every 5-bit encoding.
    assign w_op      = r_ir[31:26];
    assign w_funct   = r_ir[5:0];
    assign w_rs      = AW'({27'b0, r_ir[25:21]} % NREG);
    assign w_rt      = AW'({27'b0, r_ir[20:16]} % NREG);
    assign w_rd      = AW'({27'b0, r_ir[15:11]} % NREG);
    assign w_dbgIdx  = AW'({27'b0, dbg_sel} % NREG);
    assign w_immSext = {{16{r_ir[15]}}, r_ir[15:0]};

    // Opcode classification used by every state after FETCH.
    assign w_isRtype = (w_op == OP_RTYPE);
    assign w_isJ     = (w_op == OP_J);
    assign w_isJal   = (w_op == OP_JAL);
    assign w_isBeq   = (w_op == OP_BEQ);
    assign w_isAddi  = (w_op == OP_ADDI);
    assign w_isLw    = (w_op == OP_LW);
    assign w_isSw    = (w_op == OP_SW);
    assign w_rtypeOk = (w_funct == FN_ADD) || (w_funct == FN_SUB) ||
                       (w_funct == FN_AND) || (w_funct == FN_OR)  ||
                       (w_funct == FN_SLT);
    assign w_legal   = (w_isRtype && w_rtypeOk) || w_isJ || w_isJal ||
                       w_isBeq || w_isAddi || w_isLw || w_isSw;

    // R-type ALU; slt compares the operands as signed values.
    always_comb begin
        w_aluR = r_a + r_b;
        case (w_funct)
            FN_SUB:  w_aluR = r_a - r_b;
            FN_AND:  w_aluR = r_a & r_b;
            FN_OR:   w_aluR = r_a | r_b;
            FN_SLT:  w_aluR = {31'b0, ($signed(r_a) < $signed(r_b))};
            default: w_aluR = r_a + r_b;
        endcase
    end

    // Writeback destination and data: lw and addi target rt, R-type rd.
    always_comb begin
        w_wbIdx  = w_rd;
        w_wbData = r_aluOut;
        if (w_isLw) begin
            w_wbIdx  = w_rt;
            w_wbData = r_mdr;
        end else if (w_isAddi) begin
            w_wbIdx  = w_rt;
        end
    end

    // Memory port driven straight from the state register, so address and
    // strobes stay stable for as long as a request waits for mem_ready.
    assign mem_req   = (r_state == S_FETCH) || (r_state == S_MEM);
    assign mem_we    = (r_state == S_MEM) && w_isSw;
    assign mem_addr  = (r_state == S_MEM) ? {r_aluOut[31:2], 2'b00}
                                          : {r_pc[31:2], 2'b00};
    assign mem_wdata = r_b;

    // Completion pulse in the cycle whose exit finishes the instruction.
    assign instr_done = ((r_state == S_DECODE) && (w_isJ || w_isJal) && w_legal) ||
                        ((r_state == S_EXEC) && w_isBeq) ||
                        ((r_state == S_MEM) && w_isSw && mem_ready) ||
                        (r_state == S_WB);

    assign halted   = (r_state == S_HALT);
    assign pc_out   = r_pc;
    assign dbg_data = r_regs[w_dbgIdx];

    // Control FSM and all architectural/internal state. HALT holds every
    // register so nothing changes until the next reset; a reset during a
    // store simply returns to FETCH, so the store is never replayed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_FETCH;
            r_pc     <= RESET_PC;
            r_ir     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_aluOut <= '0;
            r_mdr    <= '0;
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (mem_ready) begin
                        r_ir    <= mem_rdata;
                        r_pc    <= r_pc + 32'd4;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_a      <= r_regs[w_rs];
                    r_b      <= r_regs[w_rt];
                    r_aluOut <= r_pc + (w_immSext << 2);
                    if (!w_legal) begin
                        r_state <= S_HALT;
                    end else if (w_isJ || w_isJal) begin
                        r_pc <= {r_pc[31:28], r_ir[25:0], 2'b00};
                        if (w_isJal) begin
                            r_regs[NREG-1] <= r_pc;
                        end
                        r_state <= S_FETCH;
                    end else begin
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (w_isRtype) begin
                        r_aluOut <= w_aluR;
                        r_state  <= S_WB;
                    end else if (w_isBeq) begin
                        if (r_a == r_b) begin
                            r_pc <= r_aluOut;
                        end
                        r_state <= S_FETCH;
                    end else begin
                        r_aluOut <= r_a + w_immSext;
                        r_state  <= (w_isLw || w_isSw) ? S_MEM : S_WB;
                    end
                end
                S_MEM: begin
                    if (mem_ready) begin
                        if (w_isLw) begin
                            r_mdr   <= mem_rdata;
                            r_state <= S_WB;
                        end else begin
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_WB: begin
                    if (w_wbIdx != '0) begin
                        r_regs[w_wbIdx] <= w_wbData;
                    end
                    r_state <= S_FETCH;
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_HALT;
                end
            endcase
        end
    end

endmodule
